parity_lane_checker: RTL

//  Streaming multi-lane parity checker with error statistics. Each valid beat

---
 rtl/parity_lane_checker.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/parity_lane_checker.sv
// -----------------------------------------------------------------------------
// parity_lane_checker
//
// Streaming multi-lane parity checker with error statistics. Each valid beat
// carries LANES data words, each with its own parity bit. Every lane is checked
// against odd (ODD=1) or even (ODD=0) parity. The data is forwarded one cycle
// later together with a per-lane error vector. A sticky error flag and a
// saturating count of error beats are kept for status reads.
//
// Optional feature (compile-time macro PARITY_GEN_EN):
//   Adds the output gen_parity[LANES]. It carries the correct parity bit for
//   each lane of the registered beat, so the block can also regenerate parity
//   on the transmit side. Without the macro the port and its logic do not exist.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   in_valid     in   input beat valid (always accepted, no backpressure)
//   in_data      in   LANES*DATA_W, lane i = in_data[i*DATA_W +: DATA_W]
//   in_parity    in   LANES, parity bit for lane i
//   clr          in   synchronous clear of err_sticky / err_count
//   out_valid    out  registered beat valid
//   out_data     out  registered copy of in_data (holds while idle)
//   out_err      out  per-lane parity mismatch, 1 = error
//   out_any_err  out  OR of out_err, qualified by out_valid
//   err_sticky   out  set by any error beat, held until clr
//   err_count    out  saturating count of beats with >=1 lane error
//   gen_parity   out  (PARITY_GEN_EN only) correct parity per lane
// -----------------------------------------------------------------------------
module parity_lane_checker #(
  parameter int DATA_W = 4,
  parameter int LANES  = 2,
  parameter int ODD    = 1,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [LANES-1:0]        in_parity,
  input  logic                    clr,
  output logic                    out_valid,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        out_err,
  output logic                    out_any_err,
  output logic                    err_sticky,
  output logic [CNT_W-1:0]        err_count
`ifdef PARITY_GEN_EN
  ,
  output logic [LANES-1:0]        gen_parity
`endif
);

  localparam logic             ODD_BIT = (ODD != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                    valid_q,  valid_d;
  logic [LANES*DATA_W-1:0] data_q,   data_d;
  logic [LANES-1:0]        err_q,    err_d;
  logic                    any_q,    any_d;
  logic                    sticky_q, sticky_d;
  logic [CNT_W-1:0]        count_q,  count_d;
  logic [LANES-1:0]        lane_err;
  logic                    beat_err;

  // A lane is in error when the XOR of its data and parity bits does not match
  // the selected parity sense.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can leave
    // it unassigned and infer a latch.
    lane_err = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_err[i] = ^{in_data[i*DATA_W +: DATA_W], in_parity[i]} ^ ODD_BIT;
    end
  end

  // Statistics count beats, not lanes.
  assign beat_err = in_valid & (|lane_err);

  always_comb begin
    valid_d  = in_valid;
    data_d   = in_valid ? in_data : data_q;
    err_d    = in_valid ? lane_err : '0;
    any_d    = beat_err;
    sticky_d = sticky_q;
    count_d  = count_q;
    // clr wins over a simultaneous error beat; that beat still reaches out_*.
    if (clr) begin
      sticky_d = 1'b0;
      count_d  = '0;
    end else if (beat_err) begin
      sticky_d = 1'b1;
      if (count_q != CNT_MAX) count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      err_q    <= '0;
      any_q    <= 1'b0;
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      err_q    <= err_d;
      any_q    <= any_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_err     = err_q;
  assign out_any_err = any_q;
  assign err_sticky  = sticky_q;
  assign err_count   = count_q;

`ifdef PARITY_GEN_EN
  logic [LANES-1:0] gen_q, gen_d;

  // Parity bit that makes data+parity satisfy the selected sense; it holds
  // together with out_data while idle.
  always_comb begin
    gen_d = gen_q;
    if (in_valid) begin
      for (int i = 0; i < LANES; i++) begin
        gen_d[i] = ^in_data[i*DATA_W +: DATA_W] ^ ODD_BIT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) gen_q <= '0;
    else     gen_q <= gen_d;
  end

  assign gen_parity = gen_q;
`endif

endmodule
